// File: rtl/sme_pkg.sv
// Shared types and constants for the string-match-engine scheduler.
package sme_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT, ST_RESP} state_e;

  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;

  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_SPACE  = 8'h20;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a 1-bit priority pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  logic r_ptr;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = r_ptr ? 2'b10 : 2'b01;
  end

  // Pointer moves past the winner when it is chosen; it is only consulted in
  // IDLE, so this is indistinguishable from moving it after RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  r_ptr <= 1'b0;
    else if (advance && |grant)  r_ptr <= grant[0];
  end
endmodule

// File: rtl/sme_sched.sv
// Schedules two requesters onto a single string-match engine: arbitrate,
// stream string/pattern bytes, wait for the result, report it back.
module sme_sched
  import sme_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant,
  input  logic [7:0] in_data0,
  input  logic [7:0] in_data1,
  input  logic       in_isstr0,
  input  logic       in_isstr1,
  input  logic       in_ispat0,
  input  logic       in_ispat1,
  output logic [7:0] sme_chardata,
  output logic       sme_isstring,
  output logic       sme_ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_match_index,
  output logic [1:0] rsp_valid,
  output logic       rsp_match,
  output logic [4:0] rsp_index,
  output logic       rsp_err,
  output logic       busy
);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_e          r_state;
  logic [5:0]      r_str_cnt;
  logic [3:0]      r_pat_cnt;
  logic            r_err;
  logic [WD_W-1:0] r_wd;

  logic [1:0] w_arb_grant;
  logic       w_advance;
  logic [7:0] w_data;
  logic       w_s, w_p, w_qual;
  logic       w_fwd_s, w_fwd_p, w_bad;
  logic       w_fall, w_wd_hit;

  assign w_advance = (r_state == ST_IDLE) && |req;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (w_advance),
    .grant   (w_arb_grant)
  );

  assign w_data   = grant[1] ? in_data1  : in_data0;
  assign w_s      = grant[1] ? in_isstr1 : in_isstr0;
  assign w_p      = grant[1] ? in_ispat1 : in_ispat0;
  assign w_qual   = w_s | w_p;
  assign w_fall   = (r_pat_cnt != 4'd0) && !w_p;
  assign w_wd_hit = (r_wd == WD_W'(TIMEOUT - 1));

  // A byte flagged as both kinds is treated as a string byte (and is an error).
  always_comb begin
    w_fwd_s = 1'b0;
    w_fwd_p = 1'b0;
    w_bad   = 1'b0;
    if (w_s) begin
      if (w_p) w_bad = 1'b1;
      if (r_pat_cnt != 4'd0 || r_str_cnt == 6'(STR_MAX)) w_bad = 1'b1;
      else                                               w_fwd_s = 1'b1;
    end else if (w_p) begin
      if (r_pat_cnt == 4'(PAT_MAX)) w_bad = 1'b1;
      else                          w_fwd_p = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      grant         <= 2'b00;
      busy          <= 1'b0;
      r_str_cnt     <= '0;
      r_pat_cnt     <= '0;
      r_err         <= 1'b0;
      r_wd          <= '0;
      sme_chardata  <= '0;
      sme_isstring  <= 1'b0;
      sme_ispattern <= 1'b0;
      rsp_valid     <= 2'b00;
      rsp_match     <= 1'b0;
      rsp_index     <= '0;
      rsp_err       <= 1'b0;
    end else begin
      rsp_valid <= 2'b00;
      // Outputs follow the selected requester only while loading; the byte
      // registered on the last LOAD cycle drains during the first WAIT cycle.
      if (r_state == ST_LOAD) begin
        sme_chardata  <= w_data;
        sme_isstring  <= w_fwd_s;
        sme_ispattern <= w_fwd_p;
      end else begin
        sme_chardata  <= '0;
        sme_isstring  <= 1'b0;
        sme_ispattern <= 1'b0;
      end

      unique case (r_state)
        ST_IDLE: begin
          r_str_cnt <= '0;
          r_pat_cnt <= '0;
          r_err     <= 1'b0;
          r_wd      <= '0;
          if (|req) begin
            grant   <= w_arb_grant;
            busy    <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_fwd_s) r_str_cnt <= r_str_cnt + 6'd1;
          if (w_fwd_p) r_pat_cnt <= r_pat_cnt + 4'd1;
          if (w_bad)   r_err     <= 1'b1;
          if (w_fall) begin
            r_wd    <= '0;
            r_state <= ST_WAIT;
          end else if (!w_qual) begin
            if (w_wd_hit) begin
              rsp_valid <= grant;
              rsp_match <= 1'b0;
              rsp_index <= '0;
              rsp_err   <= 1'b1;
              r_state   <= ST_RESP;
            end else begin
              r_wd <= r_wd + 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (sme_valid) begin
            rsp_valid <= grant;
            rsp_match <= sme_match;
            rsp_index <= sme_match_index;
            rsp_err   <= r_err;
            r_state   <= ST_RESP;
          end else if (w_wd_hit) begin
            rsp_valid <= grant;
            rsp_match <= 1'b0;
            rsp_index <= '0;
            rsp_err   <= 1'b1;
            r_state   <= ST_RESP;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        ST_RESP: begin
          grant   <= 2'b00;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
